instr_mem_pipe: RTL and testbench

INSTR_MEM_PIPE -- requirements
Module: instr_mem_pipe

---
 rtl/instr_mem_pipe_pkg.sv | 12 +
 rtl/instr_mem_array.sv | 25 ++
 rtl/instr_mem_pipe.sv | 115 +++++++++++
 tb/tb_instr_mem_pipe.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pipe_pkg.sv
// Shared types and constants for the instruction memory pipeline.
// Holds the controller state enumeration and the default no-op word.
package instr_mem_pipe_pkg;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    localparam logic [31:0] DEFAULT_NOP = 32'h0000_0000;

endpackage

// File: rtl/instr_mem_array.sv
// Instruction storage: one synchronous write port and one asynchronous read port.
// The array has no reset; the controller clears it word by word after reset.
module instr_mem_array #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_mem_pipe.sv
// Instruction memory with a clear-on-reset sequence, a program-load port and
// a registered fetch output that supports stall, flush and write-first bypass.
module instr_mem_pipe
    import instr_mem_pipe_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 4,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(DEFAULT_NOP)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_stall,
    input  logic              fetch_flush,
    output logic [DATA_W-1:0] instr_out,
    output logic              instr_valid,
    output logic              ready,
    input  logic              prog_wr_en,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_ack
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_next;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] fetch_word;
    logic              prog_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // INIT owns the write port to clear every word; RUN hands it to program load.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        mem_we      = 1'b0;
        mem_waddr   = prog_addr;
        mem_wdata   = prog_data;
        prog_accept = 1'b0;
        case (state)
            INIT: begin
                mem_we    = 1'b1;
                mem_waddr = cnt;
                mem_wdata = NOP_WORD;
                cnt_next  = cnt + ADDR_W'(1);
                if (cnt == LAST_ADDR) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                mem_we      = prog_wr_en;
                prog_accept = prog_wr_en;
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

    instr_mem_array #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk  (clk),
        .we   (mem_we),
        .waddr(mem_waddr),
        .wdata(mem_wdata),
        .raddr(fetch_addr),
        .rdata(mem_rdata)
    );

    assign ready      = (state == RUN);
    assign fetch_word = (prog_accept && (prog_addr == fetch_addr)) ? prog_data : mem_rdata;

    // Flush beats stall, stall beats a new fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_out   <= NOP_WORD;
            instr_valid <= 1'b0;
            prog_ack    <= 1'b0;
        end else begin
            prog_ack <= prog_accept;
            if (state != RUN) begin
                instr_valid <= 1'b0;
            end else if (fetch_flush) begin
                instr_out   <= NOP_WORD;
                instr_valid <= 1'b0;
            end else if (!fetch_stall) begin
                if (fetch_req) begin
                    instr_out   <= fetch_word;
                    instr_valid <= 1'b1;
                end else begin
                    instr_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Randomized scoreboard bench for instr_mem_pipe against a behavioural memory model.
module tb_instr_mem_pipe;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic              clk;
    logic              rst_n;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_stall;
    logic              fetch_flush;
    logic [DATA_W-1:0] instr_out;
    logic              instr_valid;
    logic              ready;
    logic              prog_wr_en;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic              prog_ack;

    instr_mem_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_stall(fetch_stall),
        .fetch_flush(fetch_flush),
        .instr_out  (instr_out),
        .instr_valid(instr_valid),
        .ready      (ready),
        .prog_wr_en (prog_wr_en),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .prog_ack   (prog_ack)
    );

    typedef struct {
        logic [31:0] out;
        logic        valid;
        logic        ack;
        logic        rdy;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] mdl_out;
    logic        mdl_valid;
    int          init_left;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: compares DUT outputs shortly after each edge against queued expectations.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                checkOutput("instr_out", instr_out, mon_e.out);
                checkOutput("instr_valid", 32'(instr_valid), 32'(mon_e.valid));
                checkOutput("prog_ack", 32'(prog_ack), 32'(mon_e.ack));
                checkOutput("ready", 32'(ready), 32'(mon_e.rdy));
            end
        end
    end

    // Called at a falling edge: drives one cycle, predicts the result, waits one cycle.
    task automatic applyStimulus(input logic req, input logic [ADDR_W-1:0] faddr,
                                 input logic stall, input logic flush, input logic wr,
                                 input logic [ADDR_W-1:0] waddr, input logic [31:0] wdata);
        exp_t        e;
        logic [31:0] rd;
        fetch_req   = req;
        fetch_addr  = faddr;
        fetch_stall = stall;
        fetch_flush = flush;
        prog_wr_en  = wr;
        prog_addr   = waddr;
        prog_data   = wdata;
        if (init_left > 0) begin
            ref_mem[DEPTH - init_left] = NOP;
            init_left--;
            mdl_valid = 1'b0;
            e.ack = 1'b0;
        end else begin
            rd = (wr && waddr == faddr) ? wdata : ref_mem[faddr];
            if (flush) begin
                mdl_out   = NOP;
                mdl_valid = 1'b0;
            end else if (!stall) begin
                if (req) begin
                    mdl_out   = rd;
                    mdl_valid = 1'b1;
                end else begin
                    mdl_valid = 1'b0;
                end
            end
            if (wr) ref_mem[waddr] = wdata;
            e.ack = wr;
        end
        e.out   = mdl_out;
        e.valid = mdl_valid;
        e.rdy   = (init_left == 0);
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idleRandom(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'($urandom), ADDR_W'($urandom), 1'b0, 1'b0, 1'($urandom),
                          ADDR_W'($urandom), $urandom);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_instr_out", instr_out, NOP);
        checkOutput("rst_instr_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_prog_ack", 32'(prog_ack), 32'd0);
        checkOutput("rst_ready", 32'(ready), 32'd0);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = NOP;
        mdl_out   = NOP;
        mdl_valid = 1'b0;
        init_left = DEPTH;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        fetch_req   = 1'b0;
        fetch_addr  = '0;
        fetch_stall = 1'b0;
        fetch_flush = 1'b0;
        prog_wr_en  = 1'b0;
        prog_addr   = '0;
        prog_data   = '0;

        doReset();
        idleRandom(5);
        doReset();
        idleRandom(DEPTH);

        for (int a = 0; a < DEPTH; a++) begin
            applyStimulus(1'b1, ADDR_W'(a), 1'b0, 1'b0, 1'b0, '0, '0);
        end

        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 4'd1, 32'h8CC3_0000);
        applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 4'd2, 32'h1001_0001);
        applyStimulus(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'($urandom), ADDR_W'(i + 5), 1'b1, 1'b0, 1'b0, '0, '0);
        end

        applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b1, 4'd2, 1'b1, 1'b1, 1'b0, '0, '0);
        applyStimulus(1'b1, 4'd8, 1'b0, 1'b0, 1'b1, 4'd8, 32'hFFFF_FFFD);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);

        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), ADDR_W'($urandom),
                          1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0),
                          1'($urandom_range(0, 2) == 0), ADDR_W'($urandom), $urandom);
        end

        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 4'd3, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, '0, '0);
        doReset();
        idleRandom(DEPTH);
        applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b1, 4'd8, 1'b0, 1'b0, 1'b0, '0, '0);

        @(posedge clk);
        #2;
        checkOutput("sb_drain", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
